// File: rtl/dsm_decimator_if.sv
// Bitstream-in / PCM-out bundle for dsm_decimator. The o_sat member exists only
// when DSM_DECIMATOR_SAT_FLAG_EN is defined.
interface dsm_decimator_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  i_en;
    logic                  i_bitstream;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
`ifdef DSM_DECIMATOR_SAT_FLAG_EN
    logic                  o_sat;

    modport master (output i_en, output i_bitstream, input o_data, input o_valid, input o_sat);
    modport slave  (input i_en, input i_bitstream, output o_data, output o_valid, output o_sat);
`else
    modport master (output i_en, output i_bitstream, input o_data, input o_valid);
    modport slave  (input i_en, input i_bitstream, output o_data, output o_valid);
`endif
endinterface

// File: rtl/dsm_decimator.sv
// Sinc^3 CIC decimator: 1-bit delta-sigma stream in, signed DATA_WIDTH PCM out every 2**DECIM_LOG2 enabled bits.
// Optional feature macro: DSM_DECIMATOR_SAT_FLAG_EN adds the o_sat clip flag.
module dsm_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM_LOG2 = 6,
    parameter int ACC_WIDTH  = 3*DECIM_LOG2+2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dsm_decimator_if.slave   bus
);
    localparam int SHIFT = 3*DECIM_LOG2 - (DATA_WIDTH-1);
    localparam int NSTG  = 3;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    acc_t integ_q [NSTG];
    acc_t integ_d [NSTG];
    acc_t integ_in[NSTG];
    acc_t diff_q  [NSTG];
    acc_t diff_d  [NSTG];
    acc_t comb_in [NSTG];
    acc_t comb    [NSTG];

    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    acc_t                  cap_q, cap_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;

    acc_t                  x_ext;
    acc_t                  scaled;
    logic                  clip;
    logic [DATA_WIDTH-1:0] sat_val;

    assign x_ext = bus.i_bitstream ? {{(ACC_WIDTH-1){1'b0}}, 1'b1} : {ACC_WIDTH{1'b1}};

    // Integrators feed forward from the previous stage's old value; wrap-around is intentional.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign integ_in[gi] = x_ext;
            assign comb_in[gi]  = cap_q;
        end else begin : g_rest
            assign integ_in[gi] = integ_q[gi-1];
            assign comb_in[gi]  = comb[gi-1];
        end
        assign integ_d[gi] = bus.i_en  ? integ_q[gi] + integ_in[gi] : integ_q[gi];
        assign comb[gi]    = comb_in[gi] - diff_q[gi];
        assign diff_d[gi]  = cap_vld_q ? comb_in[gi] : diff_q[gi];
    end

    always_comb begin
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        if (bus.i_en) begin
            cnt_d  = cnt_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
            tick_d = &cnt_q;
        end
        cap_d     = tick_q ? integ_q[NSTG-1] : cap_q;
        cap_vld_d = tick_q;
    end

    // Floor-shift, then clip whenever the bits above the output sign disagree.
    always_comb begin
        scaled  = comb[NSTG-1] >>> SHIFT;
        clip    = !((&scaled[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|scaled[ACC_WIDTH-1:DATA_WIDTH-1]));
        sat_val = scaled[DATA_WIDTH-1:0];
        if (clip) begin
            sat_val = scaled[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        data_d  = cap_vld_q ? sat_val : data_q;
        valid_d = cap_vld_q;
        sat_d   = cap_vld_q && clip;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                integ_q[k] <= '0;
                diff_q[k]  <= '0;
            end
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                integ_q[k] <= integ_d[k];
                diff_q[k]  <= diff_d[k];
            end
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
`ifdef DSM_DECIMATOR_SAT_FLAG_EN
    assign bus.o_sat   = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif
endmodule
